// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback mux: sub-word load extension, link PC, retired count.
// Latency 1 cycle, no stall or backpressure (WB always advances). Define WB_TRACE_EN for a write trace.
module mem_wb_stage #(
  parameter logic [31:0] PC_LINK_OFS = 32'd8,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m_valid,
  input  logic [31:0]      m_ins,
  input  logic [31:0]      m_pc,
  input  logic [31:0]      m_alu,
  input  logic [31:0]      m_rdata,
  input  logic [4:0]       m_a3,
  input  logic             m_rfwe,
  input  logic [1:0]       m_wsel,
  input  logic [2:0]       m_ldt,
  output logic             w_valid,
  output logic [31:0]      w_ins,
  output logic             rf_we,
  output logic [4:0]       rf_a3,
  output logic [31:0]      rf_wd,
  output logic [31:0]      rf_wpc,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] LDT_LB  = 3'd1;
  localparam logic [2:0] LDT_LBU = 3'd2;
  localparam logic [2:0] LDT_LH  = 3'd3;
  localparam logic [2:0] LDT_LHU = 3'd4;

  logic        w_valid_q;
  logic [31:0] w_ins_q;
  logic [31:0] w_pc_q;
  logic [31:0] w_alu_q;
  logic [31:0] w_rdata_q;
  logic [4:0]  w_a3_q;
  logic        w_rfwe_q;
  logic [1:0]  w_wsel_q;
  logic [2:0]  w_ldt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_valid_q <= 1'b0;
      w_ins_q   <= '0;
      w_pc_q    <= '0;
      w_alu_q   <= '0;
      w_rdata_q <= '0;
      w_a3_q    <= '0;
      w_rfwe_q  <= 1'b0;
      w_wsel_q  <= '0;
      w_ldt_q   <= '0;
      retired   <= '0;
    end else begin
      w_valid_q <= m_valid;
      w_ins_q   <= m_ins;
      w_pc_q    <= m_pc;
      w_alu_q   <= m_alu;
      w_rdata_q <= m_rdata;
      w_a3_q    <= m_a3;
      w_rfwe_q  <= m_rfwe;
      w_wsel_q  <= m_wsel;
      w_ldt_q   <= m_ldt;
      // Counts on load of W so the output already includes the instruction now in W.
      if (m_valid) retired <= retired + CNT_W'(1);
    end
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    ld_byte = 8'h00;
    case (w_alu_q[1:0])
      2'd0: ld_byte = w_rdata_q[7:0];
      2'd1: ld_byte = w_rdata_q[15:8];
      2'd2: ld_byte = w_rdata_q[23:16];
      2'd3: ld_byte = w_rdata_q[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = w_alu_q[1] ? w_rdata_q[31:16] : w_rdata_q[15:0];

    // Unused encodings 5..7 fall through to a full-word load.
    ld_data = w_rdata_q;
    case (w_ldt_q)
      LDT_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      LDT_LBU: ld_data = {24'h0, ld_byte};
      LDT_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      LDT_LHU: ld_data = {16'h0, ld_half};
      default: ld_data = w_rdata_q;
    endcase
  end

  always_comb begin
    rf_wd = 32'h0;
    case (w_wsel_q)
      2'd0: rf_wd = w_alu_q;
      2'd1: rf_wd = ld_data;
      2'd2: rf_wd = w_pc_q + PC_LINK_OFS;
      default: rf_wd = 32'h0;
    endcase
  end

  assign w_valid = w_valid_q;
  assign w_ins   = w_ins_q;
  assign rf_we   = w_valid_q & w_rfwe_q & (w_a3_q != 5'd0);
  assign rf_a3   = w_a3_q;
  assign rf_wpc  = w_pc_q;

`ifdef WB_TRACE_EN
  always @(posedge clk) begin
    if (!reset && rf_we)
      $display("%0t@%h: $%0d <= %h", $time, rf_wpc, rf_a3, rf_wd);
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage (CNT_W=4): directed vectors push hand-computed results, a negedge monitor pops and compares.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic [31:0] m_ins, m_pc, m_alu, m_rdata;
  logic [4:0]  m_a3;
  logic        m_rfwe;
  logic [1:0]  m_wsel;
  logic [2:0]  m_ldt;
  logic        w_valid, rf_we;
  logic [31:0] w_ins, rf_wd, rf_wpc;
  logic [4:0]  rf_a3;
  logic [3:0]  retired;

  mem_wb_stage #(.PC_LINK_OFS(32'd8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_ins(m_ins), .m_pc(m_pc),
    .m_alu(m_alu), .m_rdata(m_rdata), .m_a3(m_a3), .m_rfwe(m_rfwe),
    .m_wsel(m_wsel), .m_ldt(m_ldt), .w_valid(w_valid), .w_ins(w_ins),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_wpc(rf_wpc),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic        valid;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] wpc;
    logic [31:0] ins;
    logic [3:0]  ret;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [3:0]  ret_model = 4'd0;
  localparam logic [31:0] RD = 32'h80FF7F01;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("w_valid", {31'h0, w_valid}, {31'h0, e.valid});
      chk("rf_we",   {31'h0, rf_we},   {31'h0, e.we});
      chk("rf_a3",   {27'h0, rf_a3},   {27'h0, e.a3});
      chk("rf_wd",   rf_wd,            e.wd);
      chk("rf_wpc",  rf_wpc,           e.wpc);
      chk("w_ins",   w_ins,            e.ins);
      chk("retired", {28'h0, retired}, {28'h0, e.ret});
    end
  end

  // Drive one cycle of inputs and queue the hand-computed WB result for the next cycle.
  task automatic drive(input logic rst, input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [4:0] a3, input logic rfwe, input logic [1:0] wsel,
                       input logic [2:0] ldt, input logic exp_we, input logic [31:0] exp_wd);
    exp_t e;
    reset = rst; m_valid = v; m_ins = ins; m_pc = pc; m_alu = alu; m_rdata = rdata;
    m_a3 = a3; m_rfwe = rfwe; m_wsel = wsel; m_ldt = ldt;
    if (rst) ret_model = 4'd0;
    else if (v) ret_model = ret_model + 4'd1;
    e.cyc = cyc + 1;
    e.valid = rst ? 1'b0 : v;
    e.we    = rst ? 1'b0 : exp_we;
    e.a3    = rst ? 5'd0 : a3;
    e.wd    = rst ? 32'h0 : exp_wd;
    e.wpc   = rst ? 32'h0 : pc;
    e.ins   = rst ? 32'h0 : ins;
    e.ret   = ret_model;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; m_valid = 1'b0; m_ins = '0; m_pc = '0; m_alu = '0; m_rdata = '0;
    m_a3 = '0; m_rfwe = 1'b0; m_wsel = '0; m_ldt = '0;
    @(posedge clk);
    #1;
    //     rst  v     ins           pc            alu           rdata  a3  rfwe wsel ldt  we  wd
    drive(1'b1, 1'b1, 32'hAAAA0001, 32'h00002000, 32'h00000044, RD,  5, 1'b1, 2'd0, 3'd0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'hAAAA0002, 32'h00002004, 32'h00000048, RD,  5, 1'b1, 2'd0, 3'd0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        RD,  5, 1'b1, 2'd0, 3'd0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h01095020, 32'h00003000, 32'h12345678, RD,  8, 1'b1, 2'd0, 3'd0, 1'b1, 32'h12345678);
    drive(1'b0, 1'b1, 32'h80000001, 32'h00003004, 32'h10000001, RD,  9, 1'b1, 2'd1, 3'd1, 1'b1, 32'h0000007F);
    drive(1'b0, 1'b1, 32'h80000002, 32'h00003008, 32'h10000002, RD, 10, 1'b1, 2'd1, 3'd1, 1'b1, 32'hFFFFFFFF);
    drive(1'b0, 1'b1, 32'h90000003, 32'h0000300C, 32'h10000003, RD, 11, 1'b1, 2'd1, 3'd2, 1'b1, 32'h00000080);
    drive(1'b0, 1'b1, 32'h84000002, 32'h00003010, 32'h10000002, RD, 12, 1'b1, 2'd1, 3'd3, 1'b1, 32'hFFFF80FF);
    drive(1'b0, 1'b1, 32'h94000000, 32'h00003014, 32'h10000000, RD, 13, 1'b1, 2'd1, 3'd4, 1'b1, 32'h00007F01);
    drive(1'b0, 1'b1, 32'h8C000003, 32'h00003018, 32'h10000003, RD, 14, 1'b1, 2'd1, 3'd0, 1'b1, 32'h80FF7F01);
    drive(1'b0, 1'b1, 32'h80000000, 32'h0000301C, 32'h10000000, RD, 15, 1'b1, 2'd1, 3'd1, 1'b1, 32'h00000001);
    drive(1'b0, 1'b1, 32'h84000003, 32'h00003020, 32'h10000003, RD, 16, 1'b1, 2'd1, 3'd3, 1'b1, 32'hFFFF80FF);
    drive(1'b0, 1'b1, 32'h94000001, 32'h00003024, 32'h10000001, RD, 17, 1'b1, 2'd1, 3'd4, 1'b1, 32'h00007F01);
    drive(1'b0, 1'b1, 32'hEC000002, 32'h00003028, 32'h10000002, RD, 18, 1'b1, 2'd1, 3'd5, 1'b1, 32'h80FF7F01);
    drive(1'b0, 1'b1, 32'h0C000100, 32'h00003010, 32'h00000000, RD, 31, 1'b1, 2'd2, 3'd0, 1'b1, 32'h00003018);
    drive(1'b0, 1'b1, 32'h0C000200, 32'hFFFFFFF8, 32'h00000000, RD, 31, 1'b1, 2'd2, 3'd0, 1'b1, 32'h00000000);
    drive(1'b0, 1'b1, 32'h00000001, 32'h0000302C, 32'hDEADBEEF, RD,  3, 1'b1, 2'd3, 3'd0, 1'b1, 32'h00000000);
    drive(1'b0, 1'b1, 32'h00000020, 32'h00003030, 32'h00000077, RD,  0, 1'b1, 2'd0, 3'd0, 1'b0, 32'h00000077);
    drive(1'b0, 1'b0, 32'h00000021, 32'h00003034, 32'h00000055, RD,  4, 1'b1, 2'd0, 3'd0, 1'b0, 32'h00000055);
    drive(1'b0, 1'b1, 32'hAC000000, 32'h00003038, 32'h00000066, RD,  6, 1'b0, 2'd0, 3'd0, 1'b0, 32'h00000066);
    drive(1'b0, 1'b1, 32'h01095021, 32'h0000303C, 32'h00000099, RD,  9, 1'b1, 2'd0, 3'd0, 1'b1, 32'h00000099);
    drive(1'b1, 1'b1, 32'h01095022, 32'h00003040, 32'h000000AA, RD,  9, 1'b1, 2'd0, 3'd0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        RD,  0, 1'b0, 2'd0, 3'd0, 1'b0, 32'h0);
    // Counter wrap: 17 valid cycles from zero go 1..15, 0, 1.
    for (int i = 0; i < 17; i++)
      drive(1'b0, 1'b1, 32'h20000000 + 32'(i), 32'h00004000 + 32'(4*i), 32'h00000100 + 32'(i),
            RD, 5'd2, 1'b1, 2'd0, 3'd0, 1'b1, 32'h00000100 + 32'(i));
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, RD, 0, 1'b0, 2'd0, 3'd0, 1'b0, 32'h0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the 5-stage MIPS core.
- Captures memory-stage results each cycle, then produces the register-file write port: write enable, destination, write data, and writeback PC.
- Performs sub-word load extraction and sign/zero extension.
- Maintains a retired-instruction counter.

Parameters:
- PC_LINK_OFS, 8, byte offset added to the captured PC for link writes (jal/jalr).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- m_valid  input  1  memory-stage slot holds a real instruction (0 = bubble)
- m_ins  input  32  instruction word in the memory stage
- m_pc  input  32  PC of that instruction
- m_alu  input  32  ALU result / data-memory byte address
- m_rdata  input  32  aligned word read from data memory
- m_a3  input  5  destination register number
- m_rfwe  input  1  instruction writes the register file
- m_wsel  input  2  write-data source: 0 ALU, 1 memory, 2 PC+PC_LINK_OFS, 3 reserved
- m_ldt  input  3  load type: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU
- w_valid  output  1  writeback slot valid
- w_ins  output  32  registered instruction (for hazard unit)
- rf_we  output  1  register-file write enable
- rf_a3  output  5  register-file write address
- rf_wd  output  32  register-file write data
- rf_wpc  output  32  PC of the writing instruction
- retired  output  CNT_W  count of valid instructions that reached writeback

Behaviour:
- On every posedge clk with reset=0, all m_* inputs are captured into W registers. There is no stall or enable; WB always advances.
- Latency: inputs presented in cycle n appear on the outputs during cycle n+1. All outputs are combinational functions of the W registers only.
- Reset (synchronous) clears all W registers and retired to 0. During and after reset:
  - w_valid=0, rf_we=0, rf_a3=0, rf_wd=0, rf_wpc=0, w_ins=0.
- Reset asserted while a valid instruction is in the W registers discards it: no write is issued in the following cycle.
- Write enable: rf_we = w_valid & w_rfwe & (w_a3 != 0).
  - A bubble never writes. A write to $0 is suppressed.
- rf_a3 = w_a3; rf_wpc = w_pc. Both are passed through even when rf_we=0.
- Write-data select:
  - wsel 0: w_alu.
  - wsel 1: extended load data (see below).
  - wsel 2: w_pc + PC_LINK_OFS, modulo 2^32 (0xFFFFFFF8+8 wraps to 0).
  - wsel 3: 0.
- Load extraction uses the low address bits b = w_alu[1:0]:
  - LW: w_rdata unchanged; b is ignored.
  - LB/LBU: byte = w_rdata[8*b+7 : 8*b]. LB sign-extends, LBU zero-extends.
  - LH/LHU: half = w_alu[1] ? w_rdata[31:16] : w_rdata[15:0]. w_alu[0] is ignored. LH sign-extends, LHU zero-extends.
  - m_ldt values 5..7 are treated as LW.
- Retired counter:
  - retired increments by 1 on each posedge where the incoming m_valid=1 and reset=0. The counter therefore tracks the W registers being loaded with a valid instruction.
  - It wraps from 2^CNT_W-1 to 0.
  - It counts valid instructions regardless of m_rfwe.
  - When reset and m_valid are both high, reset wins and retired=0.

Optional Feature:
- Macro: WB_TRACE_EN.
- Defined: at each posedge where rf_we=1 and reset=0, the block prints "<time>@<rf_wpc hex>: $<rf_a3 dec> <= <rf_wd hex>" via $display. This is simulation-only, with no effect on outputs.
- Undefined: no display code is compiled; behaviour is otherwise identical.

Test Plan:
- Reset: hold reset 2 cycles with m_valid=1, m_rfwe=1, m_a3=5 -> rf_we=0, w_valid=0, retired=0 throughout and in the cycle after release.
- ALU write: m_valid=1, m_rfwe=1, m_a3=8, m_wsel=0, m_alu=0x12345678, m_pc=0x3000 -> next cycle rf_we=1, rf_a3=8, rf_wd=0x12345678, rf_wpc=0x3000, retired=1.
- Loads with m_rdata=0x80FF7F01, m_wsel=1:
  - LB at alu=...1 -> 0x0000007F.
  - LB at alu=...2 -> 0xFFFFFFFF.
  - LBU at alu=...3 -> 0x00000080.
  - LH at alu=...2 -> 0xFFFF80FF.
  - LHU at alu=...0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- Link: m_wsel=2, m_pc=0x3010, m_a3=31 -> rf_wd=0x3018, rf_a3=31; with m_pc=0xFFFFFFF8 -> rf_wd=0.
- Suppression: m_a3=0 with m_rfwe=1 -> rf_we=0, retired still increments. m_valid=0 with m_rfwe=1, m_a3=4 -> rf_we=0, retired unchanged.
- Counter wrap (CNT_W=4): 17 consecutive valid cycles -> retired sequence reaches 15, then 0, then 1.
